// File: rtl/divider_sub_ctrl_if.sv
// ---------------------------------------------------------------------------
// divider_sub_ctrl_if
// Bundles the operand/handshake inputs and the result/status outputs of the
// repeated-subtraction divider sequencer.
//   Start, Ack        : level requests from the board buttons
//   Xin, Yin          : dividend / divisor from the board switches
//   Quotient          : quotient register
//   Remainder         : working dividend, final remainder once done
//   Done, DivByZero   : completion and divide-by-zero status
//   Qi, Qc, Qd        : one-hot state indicators for the LEDs
// The master modport is the switch/button side; the slave modport is the
// sequencer itself.
// ---------------------------------------------------------------------------
interface divider_sub_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic             Ack;
  logic [WIDTH-1:0] Xin;
  logic [WIDTH-1:0] Yin;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Done;
  logic             DivByZero;
  logic             Qi;
  logic             Qc;
  logic             Qd;

  modport master (
    output Start, Ack, Xin, Yin,
    input  Quotient, Remainder, Done, DivByZero, Qi, Qc, Qd
  );

  modport slave (
    input  Start, Ack, Xin, Yin,
    output Quotient, Remainder, Done, DivByZero, Qi, Qc, Qd
  );
endinterface

// File: rtl/divider_sub_ctrl.sv
// ---------------------------------------------------------------------------
// divider_sub_ctrl
// Unsigned divider built from repeated subtraction: Start captures the
// operands, each clock in the compute state subtracts the divisor once, and
// Ack releases the result back to the idle state.
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : divider_sub_ctrl_if.slave (operands, handshake, results, LEDs)
// ---------------------------------------------------------------------------
module divider_sub_ctrl #(
  parameter int WIDTH = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  divider_sub_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    QI = 2'b00,
    QC = 2'b01,
    QD = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] quot_nxt_s;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] y_nxt_s;
  logic             dbz_r;
  logic             dbz_nxt_s;

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= QI;
      quot_r  <= ZERO_C;
      rem_r   <= ZERO_C;
      y_r     <= ZERO_C;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      quot_r  <= quot_nxt_s;
      rem_r   <= rem_nxt_s;
      y_r     <= y_nxt_s;
      dbz_r   <= dbz_nxt_s;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    next_state_s = state_r;
    quot_nxt_s   = quot_r;
    rem_nxt_s    = rem_r;
    y_nxt_s      = y_r;
    dbz_nxt_s    = dbz_r;
    case (state_r)
      QI: begin
        if (bus.Start) begin
          rem_nxt_s = bus.Xin;
          y_nxt_s   = bus.Yin;
          dbz_nxt_s = (bus.Yin == ZERO_C);
          if (bus.Yin == ZERO_C) begin
            // No subtraction can ever terminate; report saturated quotient.
            quot_nxt_s   = ONES_C;
            next_state_s = QD;
          end else begin
            quot_nxt_s   = ZERO_C;
            next_state_s = QC;
          end
        end else begin
          next_state_s = QI;
        end
      end
      QC: begin
        // The >= guard keeps the subtraction from underflowing, and the
        // quotient can reach at most all-ones for a divisor of one.
        if (rem_r >= y_r) begin
          rem_nxt_s    = rem_r - y_r;
          quot_nxt_s   = quot_r + ONE_C;
          next_state_s = QC;
        end else begin
          next_state_s = QD;
        end
      end
      QD: begin
        // Ack has priority over Start here; results stay visible in QI.
        if (bus.Ack) begin
          next_state_s = QI;
        end else begin
          next_state_s = QD;
        end
      end
      default: begin
        next_state_s = QI;
      end
    endcase
  end

  assign bus.Quotient  = quot_r;
  assign bus.Remainder = rem_r;
  assign bus.DivByZero = dbz_r;
  assign bus.Qi        = (state_r == QI);
  assign bus.Qc        = (state_r == QC);
  assign bus.Qd        = (state_r == QD);
  assign bus.Done      = (state_r == QD);

endmodule

// File: tb/tb_divider_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_divider_sub_ctrl
// Directed scenarios plus randomized Start/Ack/operand traffic. A
// transaction-level model (quotient/remainder from / and %, compute progress
// as a step count) predicts every output each cycle; literal expectations
// pin the model on the directed cases.
// ---------------------------------------------------------------------------
module tb_divider_sub_ctrl;

  localparam int W    = 4;
  localparam int ONES = (1 << W) - 1;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  divider_sub_ctrl_if #(.WIDTH(W)) bus ();

  divider_sub_ctrl #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 computing, 2 done.
  int m_phase = 0;
  int m_k     = 0;
  int m_x     = 0;
  int m_y     = 0;
  int m_q     = 0;
  int m_r     = 0;
  int m_dbz   = 0;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_x = 0; m_y = 0; m_q = 0; m_r = 0; m_dbz = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: begin
        if (bus.Start === 1'b1) begin
          m_x   = int'(bus.Xin);
          m_y   = int'(bus.Yin);
          m_dbz = (m_y == 0) ? 1 : 0;
          m_r   = m_x;
          m_k   = 0;
          if (m_y == 0) begin
            m_q     = ONES;
            m_phase = 2;
          end else begin
            m_q     = 0;
            m_phase = 1;
          end
        end
      end
      1: begin
        // Step k of the computation: k subtractions done while k <= X/Y,
        // and the step after the last subtraction moves to done.
        m_k = m_k + 1;
        if (m_k <= m_x / m_y) begin
          m_q = m_k;
          m_r = m_x - m_k * m_y;
        end else begin
          m_phase = 2;
        end
      end
      default: begin
        if (bus.Ack === 1'b1) m_phase = 0;
      end
    endcase
  endtask

  // Model advances on the same edges the DUT reacts to.
  initial begin
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) model_reset();
      else          model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("qi",        int'(bus.Qi),        (m_phase == 0) ? 1 : 0);
    chk("qc",        int'(bus.Qc),        (m_phase == 1) ? 1 : 0);
    chk("qd",        int'(bus.Qd),        (m_phase == 2) ? 1 : 0);
    chk("done",      int'(bus.Done),      (m_phase == 2) ? 1 : 0);
    chk("quotient",  int'(bus.Quotient),  m_q);
    chk("remainder", int'(bus.Remainder), m_r);
    chk("divbyzero", int'(bus.DivByZero), m_dbz);
  endtask

  task automatic tick();
    @(negedge Clk);
    compare_all();
  endtask

  task automatic start_div(input int x, input int y);
    bus.Xin   = W'(x);
    bus.Yin   = W'(y);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  // Counts cycles spent in compute, bounded so a stuck DUT still ends.
  task automatic count_qc(output int n);
    n = 0;
    while (bus.Qc === 1'b1 && n < 40) begin
      n = n + 1;
      tick();
    end
    chk("reach_done", int'(bus.Done), 1);
  endtask

  task automatic ack();
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
  endtask

  int n;

  initial begin
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.Xin   = '0;
    bus.Yin   = '0;
    repeat (3) tick();
    chk("reset_qi", int'(bus.Qi), 1);
    chk("reset_quot", int'(bus.Quotient), 0);
    Reset_n = 1'b1;
    tick();

    // 13 / 4
    start_div(13, 4);
    count_qc(n);
    chk("t1_qc_cycles", n, 4);
    chk("t1_quot", int'(bus.Quotient), 3);
    chk("t1_rem", int'(bus.Remainder), 1);
    ack();

    // 15 / 1 worst case
    start_div(15, 1);
    count_qc(n);
    chk("t2_qc_cycles", n, 16);
    chk("t2_quot", int'(bus.Quotient), 15);
    chk("t2_rem", int'(bus.Remainder), 0);
    chk("t2_dbz", int'(bus.DivByZero), 0);
    ack();

    // 3 / 5, then values held after Ack
    start_div(3, 5);
    count_qc(n);
    chk("t3_qc_cycles", n, 1);
    ack();
    chk("t3_qi", int'(bus.Qi), 1);
    chk("t3_quot_held", int'(bus.Quotient), 0);
    chk("t3_rem_held", int'(bus.Remainder), 3);

    // 9 / 0, then 8 / 2 clears the flag
    start_div(9, 0);
    count_qc(n);
    chk("t4_qc_cycles", n, 0);
    chk("t4_dbz", int'(bus.DivByZero), 1);
    chk("t4_quot", int'(bus.Quotient), 15);
    chk("t4_rem", int'(bus.Remainder), 9);
    ack();
    start_div(8, 2);
    chk("t4b_dbz", int'(bus.DivByZero), 0);
    count_qc(n);
    chk("t4b_quot", int'(bus.Quotient), 4);
    chk("t4b_rem", int'(bus.Remainder), 0);

    // Start+Ack in QD: Ack wins; held Start restarts; operand changes ignored
    bus.Xin   = 4'd5;
    bus.Yin   = 4'd2;
    bus.Start = 1'b1;
    bus.Ack   = 1'b1;
    tick();
    bus.Ack = 1'b0;
    chk("t5_ack_wins", int'(bus.Qi), 1);
    tick();
    bus.Start = 1'b0;
    chk("t5_restart", int'(bus.Qc), 1);
    bus.Xin = 4'd15;
    bus.Yin = 4'd1;
    count_qc(n);
    chk("t5_qc_cycles", n, 3);
    chk("t5_quot", int'(bus.Quotient), 2);
    chk("t5_rem", int'(bus.Remainder), 1);
    ack();

    // Reset during compute
    start_div(15, 1);
    repeat (5) tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_qi", int'(bus.Qi), 1);
    chk("t6_qc", int'(bus.Qc), 0);
    chk("t6_done", int'(bus.Done), 0);
    chk("t6_quot", int'(bus.Quotient), 0);
    chk("t6_rem", int'(bus.Remainder), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    start_div(6, 3);
    count_qc(n);
    chk("t6b_qc_cycles", n, 3);
    chk("t6b_quot", int'(bus.Quotient), 2);
    chk("t6b_rem", int'(bus.Remainder), 0);
    ack();

    // Randomized traffic, model checked every cycle
    for (int i = 0; i < 3000; i++) begin
      bus.Start = ($urandom_range(0, 3) == 0);
      bus.Ack   = ($urandom_range(0, 2) == 0);
      bus.Xin   = W'($urandom_range(0, ONES));
      bus.Yin   = W'($urandom_range(0, ONES));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
